// File: rtl/exec_unit_pkg.sv
// rtl/exec_unit_pkg.sv - op codes, flag indices, instruction fields and FSM encoding for exec_unit
package exec_unit_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_PASS = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        NZCV_N = 2'd0,
        NZCV_Z = 2'd1,
        NZCV_C = 2'd2,
        NZCV_V = 2'd3
    } nzcv_idx_e;

    localparam int OP_LSB  = 13;
    localparam int RD_LSB  = 10;
    localparam int RA_LSB  = 7;
    localparam int RB_LSB  = 4;
    localparam int FWE_BIT = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] ra;
        logic [2:0] rb;
        logic       flag_we;
    } instr_t;

endpackage

// File: rtl/exec_unit_reg_file.sv
// rtl/exec_unit_reg_file.sv - 8x8 register file, two operand reads, one debug read, one write
// R0_ZERO_EN: R0 reads as zero on every port and writes to it are dropped.
module reg_file_8x8 #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [2:0] waddr,
    input  logic [7:0] wdata,
    input  logic [2:0] ra_addr,
    output logic [7:0] ra_data,
    input  logic [2:0] rb_addr,
    output logic [7:0] rb_data,
    input  logic [2:0] dbg_addr,
    output logic [7:0] dbg_data
);

    logic [7:0] mem_q [8];
    logic [7:0] mem_d [8];

    function automatic logic [7:0] read_port(input logic [2:0] addr);
`ifdef R0_ZERO_EN
        return (addr == 3'd0) ? 8'h00 : mem_q[addr];
`else
        return mem_q[addr];
`endif
    endfunction

    assign ra_data  = read_port(ra_addr);
    assign rb_data  = read_port(rb_addr);
    assign dbg_data = read_port(dbg_addr);

    always_comb begin
        mem_d = mem_q;
`ifdef R0_ZERO_EN
        if (we && (waddr != 3'd0)) begin
            mem_d[waddr] = wdata;
        end
`else
        if (we) begin
            mem_d[waddr] = wdata;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= RESET_VAL;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - four-state (IDLE/READ/EXEC/WB) execution unit driving an external ALU
// Register file behaviour for R0 depends on R0_ZERO_EN (see reg_file_8x8).
module exec_unit
    import exec_unit_pkg::*;
#(
    parameter logic [7:0] REG_RESET_VAL = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic [7:0]  alu_result,
    input  logic [3:0]  alu_nzcv,
    output logic [3:0]  flags,
    output logic        done,
    output logic [7:0]  done_data,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    logic [1:0] state_q, state_d;
    instr_t     instr_q, instr_d, instr_dec;
    logic [7:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0] alu_op_q, alu_op_d;
    logic [7:0] res_q, res_d;
    logic [3:0] nzcv_q, nzcv_d;
    logic [3:0] flags_q, flags_d;
    logic [7:0] rf_a_data, rf_b_data;
    logic       unused_instr_bits;

    assign unused_instr_bits = ^instr[2:0];

    always_comb begin
        instr_dec.op      = instr[OP_LSB +: 3];
        instr_dec.rd      = instr[RD_LSB +: 3];
        instr_dec.ra      = instr[RA_LSB +: 3];
        instr_dec.rb      = instr[RB_LSB +: 3];
        instr_dec.flag_we = instr[FWE_BIT];
    end

    reg_file_8x8 #(
        .RESET_VAL (REG_RESET_VAL)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we       (state_q == ST_WB),
        .waddr    (instr_q.rd),
        .wdata    (res_q),
        .ra_addr  (instr_q.ra),
        .ra_data  (rf_a_data),
        .rb_addr  (instr_q.rb),
        .rb_data  (rf_b_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // The ALU operand registers double as the operand latches: loaded on leaving READ,
    // they then hold their value until the next instruction reaches EXEC.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        res_d    = res_q;
        nzcv_d   = nzcv_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    state_d = ST_READ;
                    instr_d = instr_dec;
                end
            end
            ST_READ: begin
                state_d  = ST_EXEC;
                alu_a_d  = rf_a_data;
                alu_b_d  = rf_b_data;
                alu_op_d = instr_q.op;
            end
            ST_EXEC: begin
                state_d = ST_WB;
                res_d   = alu_result;
                nzcv_d  = alu_nzcv;
            end
            default: begin
                state_d = ST_IDLE;
                if (instr_q.flag_we) begin
                    flags_d = nzcv_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            instr_q  <= '0;
            alu_a_q  <= 8'h00;
            alu_b_q  <= 8'h00;
            alu_op_q <= 3'b000;
            res_q    <= 8'h00;
            nzcv_q   <= 4'b0000;
            flags_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            res_q    <= res_d;
            nzcv_q   <= nzcv_d;
            flags_q  <= flags_d;
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign flags       = flags_q;
    assign done        = (state_q == ST_WB);
    assign done_data   = res_q;

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter: REG_RESET_VAL, 8'h00, value loaded into every register-file entry on reset.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  reset is asynchronous and active-high.
REQ-004 Instr  input  16  instruction: [15:13] Op, [12:10] Rd, [9:7] Ra, [6:4] Rb, [3] Flag_we, [2:0] reserved (ignored).
REQ-005 Instr_valid  input  1  Instr holds a valid instruction.
REQ-006 Instr_ready  output  1  block can accept an instruction this cycle.
REQ-007 ALU_A, ALU_B  output  8 each  operands to the combinational ALU.
REQ-008 ALU_Op  output  3  ALU op code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 PASS A.
REQ-009 ALU_Result  input  8  ALU result.
REQ-010 ALU_NZCV  input  4  ALU flags: [0] N, [1] Z, [2] C, [3] V.
REQ-011 Flags  output  4  architectural flag register, same bit order as ALU_NZCV.
REQ-012 Done  output  1  one-cycle pulse when an instruction retires.
REQ-013 Done_data  output  8  value written back by the retiring instruction; valid while Done=1.
REQ-014 Dbg_addr  input  3 / Dbg_data  output  8  combinational register-file read port.

Function
REQ-015 Register file SHALL be 8 entries x 8 bits, one write port, internal reads of Ra/Rb, plus the Dbg port.
REQ-016 FSM SHALL have states IDLE, READ, EXEC, WB; transitions IDLE->READ on Instr_valid&&Instr_ready, READ->EXEC, EXEC->WB, WB->IDLE, unconditionally.
REQ-017 Instr_ready SHALL be 1 only in IDLE; Instr_valid in any other state SHALL be ignored, with no queuing.
REQ-018 On accept, Instr fields SHALL be latched; Instr may change afterwards without effect.
REQ-019 In READ, RF[Ra] and RF[Rb] SHALL be latched into operand registers.
REQ-020 In EXEC, ALU_A/ALU_B/ALU_Op SHALL be driven from operand registers and latched Op; ALU_Result and ALU_NZCV SHALL be captured at the end of EXEC.
REQ-021 Outside EXEC, ALU_A, ALU_B and ALU_Op SHALL be held at the last driven values; they are 0 after reset.
REQ-022 In WB, the captured result SHALL be written to RF[Rd]; Flags SHALL be loaded from captured NZCV only if Flag_we=1, and otherwise left unchanged.
REQ-023 Done SHALL be 1 exactly during WB; Done_data SHALL equal the captured result.
REQ-024 Latency SHALL be 3 cycles: accept at edge t, Done high in cycle t+3, Instr_ready high again in cycle t+4; throughput is 1 instruction per 4 cycles.
REQ-025 Rd equal to Ra or Rb SHALL be legal; the write occurs after the operand read.
REQ-026 Back-to-back instructions SHALL observe prior write-back values.
REQ-027 Dbg_data SHALL reflect an RF write in the cycle after WB.

Reset
REQ-028 Reset SHALL force IDLE asynchronously, with Instr_ready=1, Done=0, Done_data=0, Flags=4'b0000, ALU_A=ALU_B=0, ALU_Op=000, and all RF entries set to REG_RESET_VAL.
REQ-029 Reset asserted mid-instruction SHALL abort it, with no RF write, no flag update and no Done pulse.

Configuration
REQ-030 Macro R0_ZERO_EN: when defined, R0 SHALL read as 8'h00 on all ports and writes to R0 SHALL be discarded, while Flags still update per Flag_we and Done/Done_data still report the computed result.
REQ-031 Without R0_ZERO_EN, R0 SHALL be an ordinary register.

Structure
REQ-032 A shared package SHALL hold the op-code constants, NZCV bit-index constants, instruction field positions, and the FSM state encoding.
REQ-033 The register file SHALL be a sub-module named reg_file_8x8, with 2 internal read ports, 1 debug read port and 1 write port; the FSM and datapath live in exec_unit.
REQ-034 The ALU SHALL NOT be instantiated inside exec_unit; the bench connects it externally.

Verification
REQ-035 After reset, RF preloaded R1=8'h7F, R2=8'h01, then ADD Rd=3 Ra=1 Rb=2 Flag_we=1 -> Done in cycle t+3, Done_data=8'h80, R3=8'h80, Flags=4'b1001 (N=1, V=1).
REQ-036 SUB Rd=4 Ra=2 Rb=2 Flag_we=0 -> R4=8'h00, Flags unchanged from the prior value.
REQ-037 Instr_valid held high continuously -> exactly one accept per 4 cycles, and Instr_ready=0 in READ/EXEC/WB.
REQ-038 Reset asserted during EXEC of a write to R5 -> R5=REG_RESET_VAL, Flags=0, no Done pulse, Instr_ready=1 immediately.
REQ-039 With R0_ZERO_EN: PASS A Rd=0 Ra=1 (R1=8'h7F) -> Done_data=8'h7F, Dbg_addr=0 gives Dbg_data=8'h00; without the macro, Dbg_data=8'h7F.
REQ-040 ADD Rd=1 Ra=1 Rb=1 (R1=8'h40) followed by PASS A Rd=2 Ra=1 -> R2=8'h80, confirming back-to-back write-back visibility.
